// File: rtl/definitions_pkg.sv
// rtl/definitions_pkg.sv - shared types, defaults and parity helper for uart_rx_cfg
package definitions_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  typedef struct packed {
    logic brk;
    logic par;
    logic frm;
  } rx_err_t;

  localparam int      DEF_DATA_BITS  = 8;
  localparam parity_e DEF_PARITY     = PAR_NONE;
  localparam int      DEF_STOP_BITS  = 1;
  localparam int      DEF_OVERSAMPLE = 16;
  localparam int      DEF_DIV_W      = 16;
  localparam int      DEF_FIFO_DEPTH = 4;

  // Parity bit the transmitter should have sent for a given XOR of the data bits.
  function automatic logic exp_parity(input parity_e mode, input logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, one tick every div+1 clocks
// restart reloads the divisor and suppresses the tick for that cycle.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             restart,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = !restart && (cnt == '0);

  // The divisor is only sampled at a reload, so a change takes effect cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= div;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with 3-sample vote, error flags and output FIFO
module uart_rx_cfg
  import definitions_pkg::*;
#(
  parameter int      DATA_BITS  = DEF_DATA_BITS,
  parameter parity_e PARITY     = DEF_PARITY,
  parameter int      STOP_BITS  = DEF_STOP_BITS,
  parameter int      OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int      DIV_W      = DEF_DIV_W,
  parameter int      FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 en,
  output logic [DATA_BITS-1:0] dout,
  output logic [2:0]           dout_err,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 overrun,
  input  logic                 ovr_clr,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 3;

  localparam logic [TW-1:0] VOTE_AT   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  rx_state_e state, state_nxt;
  logic rx_m, rx_s, rx_prev;
  logic tick, vote_tick, bit_end, vote, push_set;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [1:0] hist;
  logic [DATA_BITS-1:0] shreg;
  logic par_bit, frm, frm_fin;
  rx_err_t err_fin;
  logic push_req;
  logic [EW-1:0] push_entry;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [EW-1:0] head;
  logic full, empty, pop, push_ok;

  // Synchroniser flops preset to the idle-high line level; rx_prev feeds the start-edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .div     (baud_div),
    .restart (state == ST_IDLE),
    .tick    (tick)
  );

  assign vote_tick = tick && (tick_cnt == VOTE_AT);
  assign bit_end   = tick && (tick_cnt == LAST_TICK);
  assign vote      = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push_set  = 1'b0;
    if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (rx_prev && !rx_s) state_nxt = ST_START;
        ST_START:  if (vote_tick && vote) state_nxt = ST_IDLE;
                   else if (bit_end) state_nxt = ST_DATA;
        ST_DATA:   if (bit_end && bit_cnt == LAST_DATA)
                     state_nxt = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
        ST_PARITY: if (bit_end) state_nxt = ST_STOP;
        // Exit at the last stop mid-sample so a back-to-back start edge is not missed.
        ST_STOP:   if (vote_tick && bit_cnt == LAST_STOP) begin
                     state_nxt = ST_IDLE;
                     push_set  = 1'b1;
                   end
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  assign frm_fin     = frm | ~vote;
  assign err_fin.frm = frm_fin;
  assign err_fin.par = (PARITY != PAR_NONE) && (par_bit != exp_parity(PARITY, ^shreg));
  assign err_fin.brk = (shreg == '0) && ((PARITY == PAR_NONE) || !par_bit) && frm_fin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      hist       <= 2'b11;
      shreg      <= '0;
      par_bit    <= 1'b0;
      frm        <= 1'b0;
      push_req   <= 1'b0;
      push_entry <= '0;
    end else begin
      push_req <= push_set;
      if (push_set) push_entry <= {err_fin, shreg};

      if (state == ST_IDLE || state_nxt == ST_IDLE) tick_cnt <= '0;
      else if (tick) tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + TW'(1);

      if (state_nxt != state) bit_cnt <= '0;
      else if (bit_end) bit_cnt <= bit_cnt + BW'(1);

      if (tick) hist <= {hist[0], rx_s};

      if (state == ST_DATA && vote_tick) shreg <= {vote, shreg[DATA_BITS-1:1]};
      if (state == ST_PARITY && vote_tick) par_bit <= vote;

      if (state == ST_IDLE) frm <= 1'b0;
      else if (state == ST_STOP && vote_tick && !vote) frm <= 1'b1;
    end
  end

  // Extra pointer MSB separates full from empty; a same-cycle pop frees the slot being written.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign pop     = !empty && dout_ready;
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_entry;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_req && !push_ok) overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  assign head       = mem[rd_ptr[AW-1:0]];
  assign dout       = head[DATA_BITS-1:0];
  assign dout_err   = head[EW-1:DATA_BITS];
  assign dout_valid = !empty;
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - randomized self-checking bench for uart_rx_cfg, 8N1 and 7E2 builds
module tb_uart_rx_cfg;
  import definitions_pkg::*;

  logic clk = 1'b0;
  always #50 clk = ~clk;

  logic rst = 1'b1, en = 1'b1;
  logic [15:0] baud_div = 16'd3;

  logic rx_a = 1'b1, rdy_a = 1'b1, clr_a = 1'b0;
  logic [7:0] dout_a; logic [2:0] err_a; logic val_a, ovr_a, busy_a;
  logic rx_b = 1'b1, rdy_b = 1'b1, clr_b = 1'b0;
  logic [6:0] dout_b; logic [2:0] err_b; logic val_b, ovr_b, busy_b;

  uart_rx_cfg #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .OVERSAMPLE(16),
                .DIV_W(16), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .baud_div(baud_div), .en(en),
    .dout(dout_a), .dout_err(err_a), .dout_valid(val_a), .dout_ready(rdy_a),
    .overrun(ovr_a), .ovr_clr(clr_a), .busy(busy_a));

  uart_rx_cfg #(.DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(2), .OVERSAMPLE(16),
                .DIV_W(16), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .baud_div(baud_div), .en(en),
    .dout(dout_b), .dout_err(err_b), .dout_valid(val_b), .dout_ready(rdy_b),
    .overrun(ovr_b), .ovr_clr(clr_b), .busy(busy_b));

  int n_vec = 0, n_bad = 0;
  int qa[$], qb[$];
  bit movr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected FIFO entry {brk, par, frm, data} from the frame's line levels.
  function automatic int exp_a(input logic [7:0] d, input logic stp);
    int frm, brk;
    frm = stp ? 0 : 1;
    brk = (d == 8'd0 && frm == 1) ? 1 : 0;
    return (brk << 10) | (frm << 8) | int'(d);
  endfunction

  function automatic int exp_b(input logic [6:0] d, input logic p, input logic s1, input logic s2);
    int frm, par, brk;
    frm = (s1 && s2) ? 0 : 1;
    par = (p != (^d)) ? 1 : 0;
    brk = (d == 7'd0 && !p && frm == 1) ? 1 : 0;
    return (brk << 9) | (par << 8) | (frm << 7) | int'(d);
  endfunction

  function automatic logic [15:0] frame_a(input logic [7:0] d, input logic stp);
    return {6'd0, stp, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame_b(input logic [6:0] d, input logic p, input logic s1, input logic s2);
    return {5'd0, s2, s1, p, d, 1'b0};
  endfunction

  task automatic wait_clks(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic drive(input int inst, input logic v);
    if (inst == 0) rx_a = v; else rx_b = v;
  endtask

  // abort_kind 1 = reset pulse, 2 = enable drop, applied mid-bit of abort_bit.
  task automatic send(input int inst, input logic [15:0] bits, input int n,
                      input int glitch_bit, input int abort_bit, input int abort_kind);
    int bc, g0, gw;
    bc = (int'(baud_div) + 1) * 16;
    g0 = bc * 9 / 16;
    gw = bc / 16;
    for (int i = 0; i < n; i++) begin
      drive(inst, bits[i]);
      if (i == abort_bit) begin
        wait_clks(bc / 2);
        if (abort_kind == 1) begin
          rst = 1'b1;
          wait_clks(1);
          check("rst_busy", busy_a, 0);
          check("rst_valid", val_a, 0);
          check("rst_dout", dout_a, 0);
          check("rst_overrun", ovr_a, 0);
          drive(inst, 1'b1);
          wait_clks(2);
          rst = 1'b0;
        end else begin
          en = 1'b0;
          wait_clks(2);
          check("abort_busy", busy_a, 0);
          drive(inst, 1'b1);
        end
        wait_clks((n - i) * bc);
        en = 1'b1;
        return;
      end
      if (i == glitch_bit) begin
        wait_clks(g0);
        drive(inst, ~bits[i]);
        wait_clks(gw);
        drive(inst, bits[i]);
        wait_clks(bc - g0 - gw);
      end else begin
        wait_clks(bc);
      end
    end
    drive(inst, 1'b1);
    if (bits[n-1] == 1'b0) wait_clks(bc);
  endtask

  task automatic wait_drain(input int inst, input string tag);
    int t;
    t = 0;
    while (((inst == 0) ? qa.size() : qb.size()) != 0 && t < 4000) begin
      wait_clks(1);
      t++;
    end
    check(tag, (inst == 0) ? qa.size() : qb.size(), 0);
    if (inst == 0) qa.delete(); else qb.delete();
  endtask

  always @(negedge clk) begin
    #5;
    if (val_a && rdy_a) begin
      if (qa.size() == 0) check("a_spurious_valid", val_a, 0);
      else check("a_pop", {err_a, dout_a}, qa.pop_front());
    end
    if (val_b && rdy_b) begin
      if (qb.size() == 0) check("b_spurious_valid", val_b, 0);
      else check("b_pop", {err_b, dout_b}, qb.pop_front());
    end
  end

  initial begin
    #8000000;
    $display("FAIL watchdog: got timeout expected run completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic [6:0] d7;
    logic p, s1, s2, stp;
    logic [7:0] fixed_a [4];
    fixed_a[0] = 8'hA5; fixed_a[1] = 8'h5A; fixed_a[2] = 8'hFF; fixed_a[3] = 8'h00;

    wait_clks(3);
    check("reset_valid_a", val_a, 0);
    check("reset_busy_a", busy_a, 0);
    check("reset_overrun_a", ovr_a, 0);
    check("reset_dout_a", {err_a, dout_a}, 0);
    check("reset_valid_b", val_b, 0);
    rst = 1'b0;
    wait_clks(4);

    for (int i = 0; i < 4; i++) begin
      qa.push_back(exp_a(fixed_a[i], 1'b1));
      send(0, frame_a(fixed_a[i], 1'b1), 10, -1, -1, 0);
    end
    wait_drain(0, "8n1_drain");
    check("8n1_overrun", ovr_a, 0);

    for (int i = 0; i < 6; i++) begin
      baud_div = 16'($urandom_range(0, 4));
      d = 8'($urandom);
      stp = ($urandom_range(0, 3) != 0);
      qa.push_back(exp_a(d, stp));
      send(0, frame_a(d, stp), 10, -1, -1, 0);
      wait_drain(0, "rand_a_drain");
    end
    baud_div = 16'd3;
    wait_clks(4);

    qb.push_back(exp_b(7'h35, 1'b0, 1'b1, 1'b1));
    send(1, frame_b(7'h35, 1'b0, 1'b1, 1'b1), 11, -1, -1, 0);
    qb.push_back(exp_b(7'h35, 1'b1, 1'b1, 1'b1));
    send(1, frame_b(7'h35, 1'b1, 1'b1, 1'b1), 11, -1, -1, 0);
    wait_drain(1, "7e2_drain");
    for (int i = 0; i < 6; i++) begin
      d7 = 7'($urandom);
      p = (^d7) ^ ($urandom_range(0, 3) == 0);
      s1 = ($urandom_range(0, 4) != 0);
      s2 = ($urandom_range(0, 4) != 0);
      qb.push_back(exp_b(d7, p, s1, s2));
      send(1, frame_b(d7, p, s1, s2), 11, -1, -1, 0);
    end
    wait_drain(1, "rand_b_drain");

    rx_a = 1'b0;
    wait_clks(4);
    check("glitch_busy_rise", busy_a, 1);
    wait_clks(8);
    rx_a = 1'b1;
    wait_clks(48);
    check("glitch_busy_fall", busy_a, 0);
    check("glitch_no_push", val_a, 0);
    wait_clks(32);
    qa.push_back(exp_a(8'hC3, 1'b1));
    send(0, frame_a(8'hC3, 1'b1), 10, 4, -1, 0);
    d = 8'($urandom);
    qa.push_back(exp_a(d, 1'b1));
    send(0, frame_a(d, 1'b1), 10, $urandom_range(0, 9), -1, 0);
    wait_drain(0, "glitch_drain");

    qa.push_back(exp_a(8'h12, 1'b0));
    send(0, frame_a(8'h12, 1'b0), 10, -1, -1, 0);
    qa.push_back(exp_a(8'h00, 1'b0));
    send(0, frame_a(8'h00, 1'b0), 10, -1, -1, 0);
    wait_drain(0, "break_drain");

    rdy_a = 1'b0;
    movr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      if (qa.size() < 4) qa.push_back(exp_a(d, 1'b1));
      else movr = 1'b1;
      send(0, frame_a(d, 1'b1), 10, -1, -1, 0);
    end
    wait_clks(4);
    check("ovr_set", ovr_a, 32'(movr));
    check("ovr_full_valid", val_a, 1);
    clr_a = 1'b1;
    wait_clks(1);
    clr_a = 1'b0;
    wait_clks(1);
    check("ovr_clear", ovr_a, 0);
    rdy_a = 1'b1;
    wait_drain(0, "ovr_drain");
    wait_clks(2);
    check("ovr_empty", val_a, 0);

    send(0, frame_a(8'h78, 1'b1), 10, -1, 5, 1);
    qa.push_back(exp_a(8'h78, 1'b1));
    send(0, frame_a(8'h78, 1'b1), 10, -1, -1, 0);
    wait_drain(0, "rst_abort_drain");
    send(0, frame_a(8'h78, 1'b1), 10, -1, 5, 2);
    wait_clks(64);
    check("en_abort_no_push", val_a, 0);
    qa.push_back(exp_a(8'h78, 1'b1));
    send(0, frame_a(8'h78, 1'b1), 10, -1, -1, 0);
    wait_drain(0, "en_abort_drain");
    wait_clks(4);
    check("final_empty", val_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
